// File: rtl/interface_hcsr04_trena_if.sv
// Bundle of HC-SR04 front-end signals between the control side and the sensor stage.
// Pure wiring, no latency.
// No backpressure: medir is a request pulse and pronto is a one-cycle result strobe.
interface interface_hcsr04_trena_if;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        timeout;
  logic [2:0]  db_estado;

  // Control unit / sensor side: issues requests and echo, consumes results.
  modport master (
    output medir, echo,
    input  trigger, medida, pronto, timeout, db_estado
  );

  // Measurement stage side.
  modport slave (
    input  medir, echo,
    output trigger, medida, pronto, timeout, db_estado
  );
endinterface

// File: rtl/interface_hcsr04_trena.sv
// HC-SR04 driver: trigger pulse, echo width measurement, 3-digit BCD centimetres with timeout/saturation.
// Latency medir->pronto = 1 + TRIGGER_CYCLES + wait + echo width + 2 (sync) + 2 cycles.
// No backpressure: medir is ignored outside inicial; pronto is a single-cycle strobe.
module interface_hcsr04_trena #(
  parameter int TRIGGER_CYCLES = 500,
  parameter int CYCLES_PER_CM  = 2941,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input logic                    clock,
  input logic                    reset,
  interface_hcsr04_trena_if.slave bus
);

  localparam int PW = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES) : 1;
  localparam int SW = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PW-1:0] PULSE_LAST = PW'(TRIGGER_CYCLES - 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(CYCLES_PER_CM - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    INICIAL      = 3'b000,
    GERA_PULSO   = 3'b001,
    ESPERA_ECHO  = 3'b010,
    MEDE_ECHO    = 3'b011,
    ARMAZENA     = 3'b100,
    FINAL_MEDIDA = 3'b101,
    ESTOURO      = 3'b110,
    INVALIDO     = 3'b111
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [SW-1:0] sub_cnt_q, sub_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [11:0]   medida_q, medida_d;
  logic          timeout_q, timeout_d;
  logic          trigger_q, trigger_d;
  logic          pronto_q, pronto_d;
  logic          echo_meta_q, echo_meta_d;
  logic          echo_s_q, echo_s_d;

  // Decimal increment with carry units->tens->hundreds; sticks at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h999) begin
      r = v;
    end else if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    sub_cnt_d   = sub_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    bcd_d       = bcd_q;
    medida_d    = medida_q;
    timeout_d   = timeout_q;
    echo_meta_d = bus.echo;
    echo_s_d    = echo_meta_q;

    case (state_q)
      INICIAL: begin
        pulse_cnt_d = '0;
        sub_cnt_d   = '0;
        bcd_d       = '0;
        if (bus.medir) state_d = GERA_PULSO;
      end
      GERA_PULSO: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d   = ESPERA_ECHO;
          tmo_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PW'(1);
        end
      end
      ESPERA_ECHO: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (tmo_cnt_q == TMO_LAST) state_d = ESTOURO;
        else if (echo_s_q)         state_d = MEDE_ECHO;
      end
      MEDE_ECHO: begin
        // The cycle that first sees echo_s high (in espera) is not counted,
        // but the cycle that sees it fall is, so the total equals the high width.
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (sub_cnt_q == SUB_LAST) begin
          sub_cnt_d = '0;
          bcd_d     = bcd_inc(bcd_q);
        end else begin
          sub_cnt_d = sub_cnt_q + SW'(1);
        end
        if (tmo_cnt_q == TMO_LAST) state_d = ESTOURO;
        else if (!echo_s_q)        state_d = ARMAZENA;
      end
      ARMAZENA: begin
        medida_d  = bcd_q;
        timeout_d = 1'b0;
        state_d   = FINAL_MEDIDA;
      end
      FINAL_MEDIDA: begin
        state_d = INICIAL;
      end
      ESTOURO: begin
        medida_d  = 12'h999;
        timeout_d = 1'b1;
        state_d   = FINAL_MEDIDA;
      end
      default: begin
        state_d = INICIAL;
      end
    endcase

    trigger_d = (state_d == GERA_PULSO);
    pronto_d  = (state_d == FINAL_MEDIDA);
  end

  // State, counters, echo synchroniser and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INICIAL;
      pulse_cnt_q <= '0;
      sub_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      bcd_q       <= '0;
      medida_q    <= '0;
      timeout_q   <= 1'b0;
      trigger_q   <= 1'b0;
      pronto_q    <= 1'b0;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      sub_cnt_q   <= sub_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      bcd_q       <= bcd_d;
      medida_q    <= medida_d;
      timeout_q   <= timeout_d;
      trigger_q   <= trigger_d;
      pronto_q    <= pronto_d;
      echo_meta_q <= echo_meta_d;
      echo_s_q    <= echo_s_d;
    end
  end

  assign bus.trigger   = trigger_q;
  assign bus.medida    = medida_q;
  assign bus.pronto    = pronto_q;
  assign bus.timeout   = timeout_q;
  assign bus.db_estado = state_q;

endmodule

// File: tb/tb_interface_hcsr04_trena.sv
// Randomised bench for interface_hcsr04_trena against a width->centimetre reference model.
// Two instances: short timeout for the main cases, long timeout for saturation.
// Results are captured at negedge; echo/medir are driven at negedge.
module tb_interface_hcsr04_trena;

  localparam int TRIG    = 5;
  localparam int CPC     = 10;
  localparam int TO_MAIN = 2000;
  localparam int TO_SAT  = 20000;

  logic clk = 1'b0;
  logic rst;
  logic medir_r, echo_r, use_sat;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  interface_hcsr04_trena_if a ();
  interface_hcsr04_trena_if b ();

  interface_hcsr04_trena #(.TRIGGER_CYCLES(TRIG), .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TO_MAIN))
    dut (.clock(clk), .reset(rst), .bus(a));
  interface_hcsr04_trena #(.TRIGGER_CYCLES(TRIG), .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TO_SAT))
    dut_sat (.clock(clk), .reset(rst), .bus(b));

  assign a.medir = medir_r & ~use_sat;
  assign b.medir = medir_r & use_sat;
  assign a.echo  = echo_r;
  assign b.echo  = echo_r;

  logic        trig_o, pr_o, tmo_o;
  logic [11:0] med_o;
  logic [2:0]  st_o;
  assign trig_o = use_sat ? b.trigger   : a.trigger;
  assign pr_o   = use_sat ? b.pronto    : a.pronto;
  assign tmo_o  = use_sat ? b.timeout   : a.timeout;
  assign med_o  = use_sat ? b.medida    : a.medida;
  assign st_o   = use_sat ? b.db_estado : a.db_estado;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: centimetres as 3 BCD digits, clamped at 999.
  function automatic logic [11:0] to_bcd(input int cm);
    int v;
    v = (cm > 999) ? 999 : cm;
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One full measurement: dly/wid are echo delay and width (cycles) after trigger end.
  // wid==0 means no echo; stuck means echo never falls; busy pulses medir mid-echo.
  task automatic measure(input string tag, input int dly, input int wid,
                         input bit stuck, input bit busy);
    int          to_lim, lim, ntrig, npr, pr_c, exp_c;
    bit          tmo_case;
    logic [11:0] exp_med, got_med;
    logic        got_tmo;
    to_lim   = use_sat ? TO_SAT : TO_MAIN;
    tmo_case = stuck || (wid == 0);
    exp_med  = tmo_case ? 12'h999 : to_bcd(wid / CPC);
    exp_c    = tmo_case ? to_lim + 1 : dly + wid + 4;
    lim      = exp_c + 20;

    @(negedge clk);
    chk({tag, "_idle_before"}, st_o, 3'b000);
    medir_r = 1'b1;
    @(negedge clk);
    medir_r = 1'b0;
    chk({tag, "_gera"}, st_o, 3'b001);
    ntrig = 0;
    while (trig_o && ntrig < 50) begin
      ntrig++;
      @(negedge clk);
    end
    chk({tag, "_trig_len"}, ntrig, TRIG);
    chk({tag, "_espera"}, st_o, 3'b010);

    npr = 0; pr_c = -1; got_med = '0; got_tmo = 1'b0;
    for (int c = 0; c <= lim; c++) begin
      if (c > 0) @(negedge clk);
      if (pr_o) begin
        if (npr == 0) begin
          pr_c    = c;
          got_med = med_o;
          got_tmo = tmo_o;
        end
        npr++;
      end
      echo_r  = (c >= dly) && (stuck || c < dly + wid);
      medir_r = busy && (c == dly + wid / 2 || c == dly + wid / 2 + 3);
    end
    echo_r  = 1'b0;
    medir_r = 1'b0;
    chk({tag, "_pronto_cnt"}, npr, 1);
    chk({tag, "_latency"}, pr_c, exp_c);
    chk({tag, "_medida"}, got_med, exp_med);
    chk({tag, "_timeout"}, got_tmo, tmo_case);
    @(negedge clk);
    chk({tag, "_back_idle"}, st_o, 3'b000);
    chk({tag, "_trig_low"}, trig_o, 1'b0);
    chk({tag, "_hold_medida"}, med_o, exp_med);
  endtask

  initial begin
    int dly, wid, npr;
    rst = 1'b1; medir_r = 1'b0; echo_r = 1'b0; use_sat = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trigger", a.trigger, 1'b0);
    chk("rst_pronto", a.pronto, 1'b0);
    chk("rst_timeout", a.timeout, 1'b0);
    chk("rst_medida", a.medida, 12'h000);
    chk("rst_state", a.db_estado, 3'b000);
    chk("rst_sat_medida", b.medida, 12'h000);
    rst = 1'b0;

    measure("basic", 40, 123, 0, 0);
    measure("trunc", 5, 9, 0, 0);
    measure("carry", 20, 1509, 0, 0);
    measure("noecho", 0, 0, 0, 0);
    measure("recover", 10, 57, 0, 0);
    measure("stuck", 30, 1, 1, 0);
    use_sat = 1'b1;
    measure("sat", 10, 12000, 0, 0);
    use_sat = 1'b0;
    measure("busy", 15, 400, 0, 1);

    for (int i = 0; i < 6; i++) begin
      dly = $urandom_range(0, 200);
      wid = $urandom_range(1, 1500);
      measure($sformatf("rnd%0d", i), dly, wid, 0, ($urandom_range(0, 1) == 1) && wid >= 100);
    end

    // Leave 999/timeout in the outputs, then reset in the middle of an echo.
    measure("pre_rst", 0, 0, 0, 0);
    @(negedge clk);
    medir_r = 1'b1;
    @(negedge clk);
    medir_r = 1'b0;
    for (int n = 0; n < 50 && trig_o; n++) @(negedge clk);
    echo_r = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst_mid_pre_state", st_o, 3'b011);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_trigger", trig_o, 1'b0);
    chk("rst_mid_state", st_o, 3'b000);
    chk("rst_mid_medida", med_o, 12'h000);
    chk("rst_mid_timeout", tmo_o, 1'b0);
    rst = 1'b0;
    npr = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (pr_o) npr++;
      if (c == 150) echo_r = 1'b0;
    end
    chk("rst_mid_no_pronto", npr, 0);
    chk("rst_mid_idle", st_o, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
